// File: rtl/hdmi_frame_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// hdmi_frame_update_ctrl_if
//   Bundles the frame-update controller's sync, mode-change, live meter and
//   displayed-snapshot signals. The clock and reset stay outside as plain
//   ports of the controller.
//
//   slave  : the controller (consumes vs/mode_change/*_in, drives *_out
//            and the status strobes)
//   master : the side that feeds live data and reads the snapshot
// ---------------------------------------------------------------------------
interface hdmi_frame_update_ctrl_if;
    logic        vs;
    logic        mode_change;
    logic [15:0] status_in;
    logic [15:0] forced_in;
    logic [7:0]  charge_in;
    logic [7:0]  discharge_in;
    logic [7:0]  p_sourced_in;
    logic [7:0]  p_sinked_in;
    logic [7:0]  battery_in;
    logic [15:0] status_out;
    logic [15:0] forced_out;
    logic [7:0]  charge_out;
    logic [7:0]  discharge_out;
    logic [7:0]  p_sourced_out;
    logic [7:0]  p_sinked_out;
    logic [7:0]  battery_out;
    logic        upd_stb;
    logic        data_changed;
    logic        blank;
    logic        vs_lost;
    logic [7:0]  frame_cnt;

    modport slave (
        input  vs, mode_change, status_in, forced_in, charge_in, discharge_in,
               p_sourced_in, p_sinked_in, battery_in,
        output status_out, forced_out, charge_out, discharge_out,
               p_sourced_out, p_sinked_out, battery_out,
               upd_stb, data_changed, blank, vs_lost, frame_cnt
    );

    modport master (
        output vs, mode_change, status_in, forced_in, charge_in, discharge_in,
               p_sourced_in, p_sinked_in, battery_in,
        input  status_out, forced_out, charge_out, discharge_out,
               p_sourced_out, p_sinked_out, battery_out,
               upd_stb, data_changed, blank, vs_lost, frame_cnt
    );
endinterface

// File: rtl/hdmi_frame_update_ctrl.sv
// ---------------------------------------------------------------------------
// hdmi_frame_update_ctrl
//   Frame-synchronous snapshot scheduler for the video text overlay. Live
//   meter values are captured every clock, but the displayed snapshot only
//   changes on a vertical-sync start (every UPDATE_FRAMES frames in RUN), so
//   the overlay never tears. After a mode change or a loss of vsync the
//   overlay is blanked and resumes with a forced load on a clean frame.
//
//   Ports:
//     clk      pixel clock
//     reset_n  asynchronous active-low reset
//     bus      slave side of hdmi_frame_update_ctrl_if:
//              vs, mode_change (async), *_in live values  -> in
//              *_out snapshot, upd_stb, data_changed, blank,
//              vs_lost, frame_cnt                          -> out
// ---------------------------------------------------------------------------
module hdmi_frame_update_ctrl #(
    parameter int UPDATE_FRAMES = 30,
    parameter int HOLD_FRAMES   = 2,
    parameter int VS_ACTIVE_LOW = 1,
    parameter int VS_TIMEOUT    = 2000000,
    parameter int TO_W          = 21
) (
    input  logic                     clk,
    input  logic                     reset_n,
    hdmi_frame_update_ctrl_if.slave  bus
);

    localparam int SNAP_W = 72;
    localparam int DC_W   = (UPDATE_FRAMES > 1) ? $clog2(UPDATE_FRAMES) : 1;
    localparam int HC_W   = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [DC_W-1:0] DIV_LAST  = DC_W'(UPDATE_FRAMES - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_FRAMES - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(VS_TIMEOUT - 1);
    localparam logic            VS_INV    = (VS_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LOST = 2'd2;

    // True when any displayed bit would change with the new snapshot.
    function automatic logic snap_differs(input logic [SNAP_W-1:0] a,
                                          input logic [SNAP_W-1:0] b);
        return |(a ^ b);
    endfunction

    logic [SNAP_W-1:0] cap_d, cap_q, snap_d, snap_q;
    logic              vs_r1_d, vs_r1_q, vs_r2_d, vs_r2_q;
    logic              mc_s1_d, mc_s1_q, mc_s2_d, mc_s2_q, mc_s3_d, mc_s3_q;
    logic [1:0]        state_d, state_q;
    logic [HC_W-1:0]   hold_cnt_d, hold_cnt_q;
    logic [DC_W-1:0]   div_cnt_d, div_cnt_q;
    logic [TO_W-1:0]   to_cnt_d, to_cnt_q;
    logic              upd_stb_d, upd_stb_q;
    logic              data_changed_d, data_changed_q;
    logic              blank_d, blank_q;
    logic              vs_lost_d, vs_lost_q;
    logic [7:0]        frame_cnt_d, frame_cnt_q;
    logic              frame_start_s, mc_evt_s, timeout_s, load_s;

    // Input capture, vsync edge pipe and mode-change synchronizer.
    always_comb begin
        cap_d = {bus.status_in, bus.forced_in, bus.charge_in, bus.discharge_in,
                 bus.p_sourced_in, bus.p_sinked_in, bus.battery_in};
        vs_r1_d       = bus.vs ^ VS_INV;
        vs_r2_d       = vs_r1_q;
        mc_s1_d       = bus.mode_change;
        mc_s2_d       = mc_s1_q;
        mc_s3_d       = mc_s2_q;
        frame_start_s = vs_r1_q & ~vs_r2_q;
        mc_evt_s      = mc_s2_q & ~mc_s3_q;
        timeout_s     = (state_q != ST_LOST) && (to_cnt_q == TO_LAST);
    end

    // Scheduler FSM: priority mode change > vsync timeout > frame start.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        div_cnt_d  = div_cnt_q;
        load_s     = 1'b0;
        if (frame_start_s) begin
            to_cnt_d = {TO_W{1'b0}};
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + TO_W'(1'b1);
        end else begin
            to_cnt_d = to_cnt_q;
        end

        if (mc_evt_s) begin
            state_d    = ST_HOLD;
            hold_cnt_d = {HC_W{1'b0}};
            div_cnt_d  = {DC_W{1'b0}};
            to_cnt_d   = {TO_W{1'b0}};
        end else if (timeout_s) begin
            state_d  = ST_LOST;
            to_cnt_d = {TO_W{1'b0}};
        end else if (frame_start_s) begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        load_s     = 1'b1;
                        state_d    = ST_RUN;
                        hold_cnt_d = {HC_W{1'b0}};
                        div_cnt_d  = {DC_W{1'b0}};
                    end else begin
                        hold_cnt_d = hold_cnt_q + HC_W'(1'b1);
                    end
                end
                ST_RUN: begin
                    if (div_cnt_q == DIV_LAST) begin
                        load_s    = 1'b1;
                        div_cnt_d = {DC_W{1'b0}};
                    end else begin
                        div_cnt_d = div_cnt_q + DC_W'(1'b1);
                    end
                end
                ST_LOST: begin
                    // Resume on this frame boundary, but load only after HOLD.
                    state_d    = ST_HOLD;
                    hold_cnt_d = {HC_W{1'b0}};
                end
                default: begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = {HC_W{1'b0}};
                    div_cnt_d  = {DC_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Snapshot register, strobes and status outputs.
    always_comb begin
        if (load_s) begin
            snap_d = cap_q;
        end else begin
            snap_d = snap_q;
        end
        upd_stb_d      = load_s;
        data_changed_d = load_s & snap_differs(cap_q, snap_q);
        blank_d        = (state_d != ST_RUN);
        vs_lost_d      = (state_d == ST_LOST);
        if (frame_start_s) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // State and output registers, cleared immediately by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q          <= {SNAP_W{1'b0}};
            snap_q         <= {SNAP_W{1'b0}};
            vs_r1_q        <= 1'b0;
            vs_r2_q        <= 1'b0;
            mc_s1_q        <= 1'b0;
            mc_s2_q        <= 1'b0;
            mc_s3_q        <= 1'b0;
            state_q        <= ST_HOLD;
            hold_cnt_q     <= {HC_W{1'b0}};
            div_cnt_q      <= {DC_W{1'b0}};
            to_cnt_q       <= {TO_W{1'b0}};
            upd_stb_q      <= 1'b0;
            data_changed_q <= 1'b0;
            blank_q        <= 1'b1;
            vs_lost_q      <= 1'b0;
            frame_cnt_q    <= 8'd0;
        end else begin
            cap_q          <= cap_d;
            snap_q         <= snap_d;
            vs_r1_q        <= vs_r1_d;
            vs_r2_q        <= vs_r2_d;
            mc_s1_q        <= mc_s1_d;
            mc_s2_q        <= mc_s2_d;
            mc_s3_q        <= mc_s3_d;
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            div_cnt_q      <= div_cnt_d;
            to_cnt_q       <= to_cnt_d;
            upd_stb_q      <= upd_stb_d;
            data_changed_q <= data_changed_d;
            blank_q        <= blank_d;
            vs_lost_q      <= vs_lost_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign bus.status_out    = snap_q[71:56];
    assign bus.forced_out    = snap_q[55:40];
    assign bus.charge_out    = snap_q[39:32];
    assign bus.discharge_out = snap_q[31:24];
    assign bus.p_sourced_out = snap_q[23:16];
    assign bus.p_sinked_out  = snap_q[15:8];
    assign bus.battery_out   = snap_q[7:0];
    assign bus.upd_stb       = upd_stb_q;
    assign bus.data_changed  = data_changed_q;
    assign bus.blank         = blank_q;
    assign bus.vs_lost       = vs_lost_q;
    assign bus.frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_hdmi_frame_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hdmi_frame_update_ctrl
//   Directed bench. u_dut_lo: active-low vs, UPDATE_FRAMES=3, HOLD_FRAMES=2.
//   u_dut_hi: active-high vs, UPDATE_FRAMES=1, HOLD_FRAMES=1.
//   Both use VS_TIMEOUT=5000. Inputs are driven and outputs sampled 1 time
//   unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_hdmi_frame_update_ctrl;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    hdmi_frame_update_ctrl_if bus_lo ();
    hdmi_frame_update_ctrl_if bus_hi ();

    // {upd_stb, data_changed, blank, vs_lost}
    logic [3:0] lo_flags;
    logic [3:0] hi_flags;
    assign lo_flags = {bus_lo.upd_stb, bus_lo.data_changed, bus_lo.blank, bus_lo.vs_lost};
    assign hi_flags = {bus_hi.upd_stb, bus_hi.data_changed, bus_hi.blank, bus_hi.vs_lost};

    hdmi_frame_update_ctrl #(
        .UPDATE_FRAMES(3), .HOLD_FRAMES(2), .VS_ACTIVE_LOW(1),
        .VS_TIMEOUT(5000), .TO_W(13)
    ) u_dut_lo (
        .clk(clk), .reset_n(reset_n), .bus(bus_lo)
    );

    hdmi_frame_update_ctrl #(
        .UPDATE_FRAMES(1), .HOLD_FRAMES(1), .VS_ACTIVE_LOW(0),
        .VS_TIMEOUT(5000), .TO_W(13)
    ) u_dut_hi (
        .clk(clk), .reset_n(reset_n), .bus(bus_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Assert active-low vs; returns just after the edge that performs a load.
    task automatic lo_vs_fall();
        bus_lo.vs = 1'b0;
        step(2);
    endtask

    // Finish a u_dut_lo frame: keep vs low a little, then inactive.
    task automatic lo_frame_rest();
        step(3);
        bus_lo.vs = 1'b1;
        step(90);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus_lo.vs = 1'b1; bus_lo.mode_change = 1'b0;
        bus_lo.status_in = 16'h0000; bus_lo.forced_in = 16'h0000;
        bus_lo.charge_in = 8'h00; bus_lo.discharge_in = 8'h00;
        bus_lo.p_sourced_in = 8'h00; bus_lo.p_sinked_in = 8'h00; bus_lo.battery_in = 8'h00;
        bus_hi.vs = 1'b0; bus_hi.mode_change = 1'b0;
        bus_hi.status_in = 16'h0000; bus_hi.forced_in = 16'h0000;
        bus_hi.charge_in = 8'h00; bus_hi.discharge_in = 8'h00;
        bus_hi.p_sourced_in = 8'h00; bus_hi.p_sinked_in = 8'h00; bus_hi.battery_in = 8'h00;
        step(3);
        checks++;
        if (lo_flags !== 4'b0010) begin
            errors++; $display("FAIL reset_flags: got %b expected %b", lo_flags, 4'b0010);
        end
        checks++;
        if ({bus_lo.status_out, bus_lo.charge_out, bus_lo.battery_out, bus_lo.frame_cnt} !== 40'h0) begin
            errors++; $display("FAIL reset_outs: got %h expected 0",
                {bus_lo.status_out, bus_lo.charge_out, bus_lo.battery_out, bus_lo.frame_cnt});
        end
        bus_lo.charge_in = 8'h2A;
        bus_lo.battery_in = 8'h10;
        reset_n = 1'b1;
        step(5);
    endtask

    task automatic test_hold_to_run();
        lo_vs_fall();
        checks++;
        if (lo_flags !== 4'b0010) begin
            errors++; $display("FAIL hold_frame1_flags: got %b expected %b", lo_flags, 4'b0010);
        end
        checks++;
        if (bus_lo.frame_cnt !== 8'd1) begin
            errors++; $display("FAIL hold_frame1_cnt: got %0d expected 1", bus_lo.frame_cnt);
        end
        lo_frame_rest();
        lo_vs_fall();
        checks++;
        if (lo_flags !== 4'b1100) begin
            errors++; $display("FAIL hold_load_flags: got %b expected %b", lo_flags, 4'b1100);
        end
        checks++;
        if (bus_lo.charge_out !== 8'h2A || bus_lo.battery_out !== 8'h10) begin
            errors++; $display("FAIL hold_load_data: got %h/%h expected 2a/10",
                bus_lo.charge_out, bus_lo.battery_out);
        end
        step(1);
        checks++;
        if (bus_lo.upd_stb !== 1'b0) begin
            errors++; $display("FAIL upd_stb_width: got %b expected 0", bus_lo.upd_stb);
        end
        lo_frame_rest();
    endtask

    task automatic test_run_divider();
        // Frames 3..5: divider counts 1, 2, then reloads unchanged data.
        for (int f = 3; f <= 5; f++) begin
            lo_vs_fall();
            checks++;
            if (lo_flags !== ((f == 5) ? 4'b1000 : 4'b0000)) begin
                errors++; $display("FAIL div_frame%0d_flags: got %b expected %b", f, lo_flags,
                    ((f == 5) ? 4'b1000 : 4'b0000));
            end
            lo_frame_rest();
        end
        // Frame 6: change battery mid-frame.
        lo_vs_fall();
        bus_lo.battery_in = 8'h11;
        lo_frame_rest();
        lo_vs_fall();
        checks++;
        if (bus_lo.upd_stb !== 1'b0 || bus_lo.battery_out !== 8'h10) begin
            errors++; $display("FAIL div_frame7: got stb=%b batt=%h expected stb=0 batt=10",
                bus_lo.upd_stb, bus_lo.battery_out);
        end
        lo_frame_rest();
        lo_vs_fall();
        checks++;
        if (lo_flags !== 4'b1100 || bus_lo.battery_out !== 8'h11) begin
            errors++; $display("FAIL div_frame8: got flags=%b batt=%h expected flags=1100 batt=11",
                lo_flags, bus_lo.battery_out);
        end
        lo_frame_rest();
    endtask

    task automatic test_mode_change();
        lo_vs_fall(); lo_frame_rest();               // frame 9
        lo_vs_fall(); bus_lo.charge_in = 8'h55; lo_frame_rest();   // frame 10
        // Frame 11 would be a scheduled load; mc_evt lands on its frame start.
        bus_lo.mode_change = 1'b1;
        step(1);
        bus_lo.vs = 1'b0;
        step(2);
        checks++;
        if (lo_flags !== 4'b0010) begin
            errors++; $display("FAIL mc_flags: got %b expected %b", lo_flags, 4'b0010);
        end
        checks++;
        if (bus_lo.charge_out !== 8'h2A || bus_lo.frame_cnt !== 8'd11) begin
            errors++; $display("FAIL mc_noload: got charge=%h cnt=%0d expected charge=2a cnt=11",
                bus_lo.charge_out, bus_lo.frame_cnt);
        end
        step(2);
        bus_lo.mode_change = 1'b0;
        step(2);
        bus_lo.vs = 1'b1;
        step(90);
        lo_vs_fall();                                // frame 12, HOLD
        checks++;
        if (lo_flags !== 4'b0010) begin
            errors++; $display("FAIL mc_hold_flags: got %b expected %b", lo_flags, 4'b0010);
        end
        lo_frame_rest();
        lo_vs_fall();                                // frame 13, forced load
        checks++;
        if (lo_flags !== 4'b1100 || bus_lo.charge_out !== 8'h55) begin
            errors++; $display("FAIL mc_resume: got flags=%b charge=%h expected flags=1100 charge=55",
                lo_flags, bus_lo.charge_out);
        end
        lo_frame_rest();
    endtask

    task automatic test_vs_loss();
        // 93 cycles have elapsed since the last frame start; timeout at 5000.
        step(4906);
        checks++;
        if (lo_flags !== 4'b0000) begin
            errors++; $display("FAIL lost_before: got %b expected %b", lo_flags, 4'b0000);
        end
        step(1);
        checks++;
        if (lo_flags !== 4'b0011 || bus_lo.charge_out !== 8'h55) begin
            errors++; $display("FAIL lost_enter: got flags=%b charge=%h expected flags=0011 charge=55",
                lo_flags, bus_lo.charge_out);
        end
        step(50);
        lo_vs_fall();
        checks++;
        if (lo_flags !== 4'b0010) begin
            errors++; $display("FAIL lost_exit: got %b expected %b", lo_flags, 4'b0010);
        end
        lo_frame_rest();
        lo_vs_fall();
        checks++;
        if (lo_flags !== 4'b0010) begin
            errors++; $display("FAIL lost_hold: got %b expected %b", lo_flags, 4'b0010);
        end
        lo_frame_rest();
        lo_vs_fall();
        checks++;
        if (lo_flags !== 4'b1000) begin
            errors++; $display("FAIL lost_resume: got %b expected %b", lo_flags, 4'b1000);
        end
        lo_frame_rest();
    endtask

    task automatic test_mid_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if (lo_flags !== 4'b0010 || bus_lo.charge_out !== 8'h00 ||
            bus_lo.battery_out !== 8'h00 || bus_lo.frame_cnt !== 8'd0) begin
            errors++; $display("FAIL midrst_async: got flags=%b charge=%h batt=%h cnt=%0d expected 0010/00/00/0",
                lo_flags, bus_lo.charge_out, bus_lo.battery_out, bus_lo.frame_cnt);
        end
        step(2);
        reset_n = 1'b1;
        step(3);
        checks++;
        if (lo_flags !== 4'b0010) begin
            errors++; $display("FAIL midrst_release: got %b expected %b", lo_flags, 4'b0010);
        end
        lo_vs_fall();
        checks++;
        if (lo_flags !== 4'b0010) begin
            errors++; $display("FAIL midrst_hold: got %b expected %b", lo_flags, 4'b0010);
        end
        lo_frame_rest();
        lo_vs_fall();
        checks++;
        if (lo_flags !== 4'b1100 || bus_lo.charge_out !== 8'h55 ||
            bus_lo.battery_out !== 8'h11 || bus_lo.frame_cnt !== 8'd2) begin
            errors++; $display("FAIL midrst_run: got flags=%b charge=%h batt=%h cnt=%0d expected 1100/55/11/2",
                lo_flags, bus_lo.charge_out, bus_lo.battery_out, bus_lo.frame_cnt);
        end
        lo_frame_rest();
    endtask

    task automatic test_active_high_wrap();
        logic [15:0] exp_status;
        checks++;
        if (hi_flags !== 4'b0010) begin
            errors++; $display("FAIL hi_start: got %b expected %b", hi_flags, 4'b0010);
        end
        for (int i = 0; i < 260; i++) begin
            exp_status = 16'h0100 + 16'(i);
            bus_hi.status_in = exp_status;
            bus_hi.vs = 1'b1;
            step(2);
            checks++;
            if (hi_flags !== 4'b1100 || bus_hi.status_out !== exp_status) begin
                errors++; $display("FAIL hi_rise_load%0d: got flags=%b status=%h expected flags=1100 status=%h",
                    i, hi_flags, bus_hi.status_out, exp_status);
            end
            step(3);
            bus_hi.status_in = 16'hDEAD;
            bus_hi.vs = 1'b0;
            step(2);
            checks++;
            if (bus_hi.upd_stb !== 1'b0 || bus_hi.status_out !== exp_status) begin
                errors++; $display("FAIL hi_fall_noload%0d: got stb=%b status=%h expected stb=0 status=%h",
                    i, bus_hi.upd_stb, bus_hi.status_out, exp_status);
            end
            step(13);
        end
        checks++;
        if (bus_hi.frame_cnt !== 8'd4) begin
            errors++; $display("FAIL hi_frame_wrap: got %0d expected 4", bus_hi.frame_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_hold_to_run();
        test_run_divider();
        test_mode_change();
        test_vs_loss();
        test_mid_reset();
        test_active_high_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
